niosii_system_sysid_uptime: RTL

- Parametrised successor to the single-word system ID slave.
- Avalon-MM slave exposing an eight-word map: system ID, build timestamp, version, a read/write scratch word, a 64-bit-visible uptime counter with a coherent high-word snapshot, and a control word.
- Reads are pipelined with fixed latency 1.
- Sits on the Nios II data master's slave fabric; software uses it for image identification and a free-running timebase.

---
 rtl/niosii_system_sysid_uptime_if.sv | 25 ++
 rtl/niosii_system_sysid_uptime.sv | 136 +++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_uptime_if.sv
// Avalon-MM slave bus bundle for the system ID / uptime block.
`timescale 1ns/1ps
interface niosii_system_sysid_uptime_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [BW-1:0] byteenable;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/niosii_system_sysid_uptime.sv
// System ID / build info slave with scratch word and a prescaled uptime counter.
// Reading UPTIME_LO snapshots the upper counter bits so a later UPTIME_HI read is coherent.
`timescale 1ns/1ps
module niosii_system_sysid_uptime #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned CNT_W        = 48,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  niosii_system_sysid_uptime_if.slave   bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = 16;

  localparam logic [2:0] A_SYSID   = 3'd0;
  localparam logic [2:0] A_STAMP   = 3'd1;
  localparam logic [2:0] A_VERSION = 3'd2;
  localparam logic [2:0] A_SCRATCH = 3'd3;
  localparam logic [2:0] A_LO      = 3'd4;
  localparam logic [2:0] A_HI      = 3'd5;
  localparam logic [2:0] A_CTRL    = 3'd6;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [DW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [PW-1:0]    presc_q,   presc_d;
  logic [DW-1:0]    shadow_q,  shadow_d;
  logic [DW-1:0]    staging_q, staging_d;
  logic             freeze_q,  freeze_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic             rvalid_q,  rvalid_d;

  logic [DW-1:0]    rmux_c;
  logic             tick_c;

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

  // Read mux sees register contents before any same-cycle update.
  always_comb begin
    rmux_c = '0;
    case (bus.address)
      A_SYSID:   rmux_c = SYSTEM_ID;
      A_STAMP:   rmux_c = TIMESTAMP;
      A_VERSION: rmux_c = VERSION;
      A_SCRATCH: rmux_c = scratch_q;
      A_LO:      rmux_c = cnt_q[DW-1:0];
      A_HI:      rmux_c = shadow_q;
      A_CTRL:    rmux_c = DW'(freeze_q);
      default:   rmux_c = '0;
    endcase
  end

  assign tick_c = (presc_q == PRE_LAST) && !freeze_q;

  // Next-state: tick first, then bus writes override it (clear/load beat tick).
  always_comb begin
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    shadow_d  = shadow_q;
    staging_d = staging_q;
    freeze_d  = freeze_q;
    rdata_d   = rdata_q;
    rvalid_d  = bus.read;

    if (bus.read) begin
      rdata_d = rmux_c;
      if (bus.address == A_LO) begin
        shadow_d = DW'(cnt_q >> DW);
      end
    end

    if (!freeze_q) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
    end
    if (tick_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.write) begin
      case (bus.address)
        A_SCRATCH: begin
          for (int k = 0; k < BW; k++) begin
            if (bus.byteenable[k]) begin
              scratch_d[8*k +: 8] = bus.writedata[8*k +: 8];
            end
          end
        end
        A_LO: staging_d = bus.writedata;
        A_HI: begin
          cnt_d   = CNT_W'({bus.writedata, staging_q});
          presc_d = '0;
        end
        A_CTRL: begin
          freeze_d = bus.writedata[0];
          if (bus.writedata[1]) begin
            cnt_d   = '0;
            presc_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= SCRATCH_INIT;
      cnt_q     <= '0;
      presc_q   <= '0;
      shadow_q  <= '0;
      staging_q <= '0;
      freeze_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      staging_q <= staging_d;
      freeze_q  <= freeze_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule
